// File: rtl/string_char_packer.sv
// rtl/string_char_packer.sv - packs 7-bit chars into an 11-char POV string with valid/ack handoff
// Optional feature macro: PACKER_TIMEOUT_EN (idle flush of a partial string)
module string_char_packer #(
  parameter int                 NUM_CHARS      = 11,
  parameter int                 CHAR_W         = 7,
  parameter logic [CHAR_W-1:0]  TERM_CHAR      = 7'h0D,
  parameter logic [CHAR_W-1:0]  PAD_CHAR       = 7'h00,
  parameter int                 TIMEOUT_CYCLES = 50_000_000,
  localparam int                STR_W          = NUM_CHARS * CHAR_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [0:CHAR_W-1] CharIn,
  input  logic             CharValid,
  output logic             CharReady,
  input  logic             StringAck,
  output logic [0:STR_W-1] StringPOV,
  output logic             StringValid,
  output logic [3:0]       CharCount
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [0:STR_W-1] buffer_q;
  logic [0:STR_W-1] pov_q;
  logic [3:0]       count_q;

  logic             accept;
  logic             is_term;
  logic             store;
  logic             complete;
  logic             timeout_fire;
  logic [3:0]       fill_cnt;
  logic [0:STR_W-1] buf_wr;
  logic [0:STR_W-1] padded;

  assign accept  = CharValid && (state_q == ACCUM);
  assign is_term = (CharIn == TERM_CHAR);
  assign store   = accept && !is_term;

  // A string completes on the last slot, on a terminator after at least one char, or on idle flush
  assign complete = (store && (count_q == 4'(NUM_CHARS - 1)))
                 || (accept && is_term && (count_q != 4'd0))
                 || timeout_fire;

`ifdef PACKER_TIMEOUT_EN
  localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] idle_q, idle_d;

  // Idle counter: runs only while a partial string sits in ACCUM; any accepted char wins over expiry
  always_comb begin
    idle_d       = idle_q;
    timeout_fire = 1'b0;
    if ((state_q != ACCUM) || accept || (count_q == 4'd0)) begin
      idle_d = '0;
    end else if (idle_q == TIMEOUT_LAST) begin
      idle_d       = '0;
      timeout_fire = 1'b1;
    end else begin
      idle_d = idle_q + 26'd1;
    end
  end

  // Idle counter register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) idle_q <= '0;
    else       idle_q <= idle_d;
  end
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_fire          = 1'b0;
`endif

  // Merge the incoming char into the buffer and pad every slot past the fill point
  always_comb begin
    buf_wr = buffer_q;
    if (store) buf_wr[int'(count_q)*CHAR_W +: CHAR_W] = CharIn;
    fill_cnt = store ? (count_q + 4'd1) : count_q;
    padded   = '0;
    for (int k = 0; k < NUM_CHARS; k++) begin
      padded[k*CHAR_W +: CHAR_W] = (4'(k) < fill_cnt) ? buf_wr[k*CHAR_W +: CHAR_W] : PAD_CHAR;
    end
  end

  // State register
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state_q <= ACCUM;
    else       state_q <= state_d;
  end

  // Next state: ACCUM until a string completes, HOLD until the consumer acks
  always_comb begin
    state_d = state_q;
    case (state_q)
      ACCUM:   if (complete)  state_d = HOLD;
      HOLD:    if (StringAck) state_d = ACCUM;
      default: state_d = ACCUM;
    endcase
  end

  // Datapath: publish the padded string on completion, otherwise append accepted chars
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      buffer_q <= '0;
      pov_q    <= '0;
      count_q  <= '0;
    end else if (complete) begin
      pov_q    <= padded;
      buffer_q <= '0;
      count_q  <= '0;
    end else if (store) begin
      buffer_q <= buf_wr;
      count_q  <= count_q + 4'd1;
    end
  end

  // Outputs: ready/valid follow the state, data comes straight from registers
  always_comb begin
    CharReady   = (state_q == ACCUM);
    StringValid = (state_q == HOLD);
    StringPOV   = pov_q;
    CharCount   = count_q;
  end

endmodule

// File: tb/tb_string_char_packer.sv
// tb/tb_string_char_packer.sv - scoreboard bench for string_char_packer
module tb_string_char_packer;

  logic        clk = 1'b0;
  logic        Reset;
  logic [0:6]  CharIn;
  logic        CharValid;
  logic        CharReady;
  logic        StringAck;
  logic [0:76] StringPOV;
  logic        StringValid;
  logic [3:0]  CharCount;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [0:76] exp_q[$];
  logic        sv_prev = 1'b0;

  string_char_packer #(.TIMEOUT_CYCLES(20)) dut (
    .clk         (clk),
    .Reset       (Reset),
    .CharIn      (CharIn),
    .CharValid   (CharValid),
    .CharReady   (CharReady),
    .StringAck   (StringAck),
    .StringPOV   (StringPOV),
    .StringValid (StringValid),
    .CharCount   (CharCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] c);
    CharIn    = c;
    CharValid = 1'b1;
    tick();
    CharValid = 1'b0;
  endtask

  // Monitor: each new StringValid rise must match the oldest expected string
  always @(negedge clk) begin
    if (StringValid && !sv_prev) begin
      if (exp_q.size() == 0) chk("unexpected_string", 1'b1, 1'b0);
      else chk("string_pov", StringPOV, exp_q.pop_front());
    end
    sv_prev = StringValid;
  end

  logic [6:0] msg1 [11] = '{7'h48, 7'h4F, 7'h4C, 7'h41, 7'h20, 7'h4D, 7'h55, 7'h4E, 7'h44, 7'h4F, 7'h21};
  logic [0:6] slice;
  int         waited;

  initial begin
    Reset = 1'b1; CharIn = '0; CharValid = 1'b0; StringAck = 1'b0;
    tick(); tick();
    chk("rst_count", CharCount, 4'd0);
    chk("rst_valid", StringValid, 1'b0);
    chk("rst_pov", StringPOV, 77'd0);
    Reset = 1'b0;
    tick();
    chk("rst_ready", CharReady, 1'b1);

    // Full 11-char string
    exp_q.push_back({7'h48, 7'h4F, 7'h4C, 7'h41, 7'h20, 7'h4D, 7'h55, 7'h4E, 7'h44, 7'h4F, 7'h21});
    for (int i = 0; i < 11; i++) begin
      send(msg1[i]);
      if (i == 4) chk("count_5", CharCount, 4'd5);
      if (i == 9) chk("valid_before_last", StringValid, 1'b0);
    end
    chk("full_valid", StringValid, 1'b1);
    chk("full_ready", CharReady, 1'b0);
    chk("full_count", CharCount, 4'd0);
    slice = StringPOV[0:6];
    chk("full_slot0", slice, 7'h48);
    slice = StringPOV[70:76];
    chk("full_slot10", slice, 7'h21);

    // HOLD with chars offered: nothing accepted
    CharIn = 7'h33; CharValid = 1'b1;
    repeat (5) tick();
    chk("hold_valid", StringValid, 1'b1);
    chk("hold_pov", StringPOV, {7'h48, 7'h4F, 7'h4C, 7'h41, 7'h20, 7'h4D, 7'h55, 7'h4E, 7'h44, 7'h4F, 7'h21});
    chk("hold_count", CharCount, 4'd0);
    StringAck = 1'b1;
    tick();
    CharValid = 1'b0;
    chk("ack_valid", StringValid, 1'b0);
    chk("ack_ready", CharReady, 1'b1);
    chk("ack_count", CharCount, 4'd0);
    tick();
    chk("ack_held_valid", StringValid, 1'b0);
    chk("ack_held_ready", CharReady, 1'b1);
    StringAck = 1'b0;

    // Early terminator pads with zeros
    exp_q.push_back({7'h48, 7'h49, 63'd0});
    send(7'h48);
    send(7'h49);
    send(7'h0D);
    chk("term_valid", StringValid, 1'b1);
    chk("term_count", CharCount, 4'd0);
    StringAck = 1'b1; tick(); StringAck = 1'b0;

    // Terminator with empty buffer is discarded
    send(7'h0D);
    chk("empty_term_valid", StringValid, 1'b0);
    chk("empty_term_count", CharCount, 4'd0);
    send(7'h41);
    chk("after_empty_count", CharCount, 4'd1);

    // Async reset mid-string
    for (int i = 0; i < 5; i++) send(7'(7'h42 + i));
    chk("mid_count", CharCount, 4'd6);
    #1 Reset = 1'b1;
    #1;
    chk("async_mid_count", CharCount, 4'd0);
    chk("async_mid_pov", StringPOV, 77'd0);
    chk("async_mid_ready", CharReady, 1'b1);
    tick();
    Reset = 1'b0;
    tick();
    chk("mid_release_ready", CharReady, 1'b1);

    // Async reset during HOLD
    exp_q.push_back({7'h30, 7'h31, 7'h32, 7'h33, 7'h34, 7'h35, 7'h36, 7'h37, 7'h38, 7'h39, 7'h3A});
    for (int i = 0; i < 11; i++) send(7'(7'h30 + i));
    chk("hold2_valid", StringValid, 1'b1);
    #6 Reset = 1'b1;
    #1;
    chk("async_hold_valid", StringValid, 1'b0);
    chk("async_hold_pov", StringPOV, 77'd0);
    tick();
    Reset = 1'b0;
    tick();
    chk("hold_release_ready", CharReady, 1'b1);
    exp_q.push_back({7'h55, 70'd0});
    send(7'h55);
    send(7'h0D);
    chk("slot0_valid", StringValid, 1'b1);
    StringAck = 1'b1; tick(); StringAck = 1'b0;

    // Idle behaviour with a single buffered char
    send(7'h41);
`ifdef PACKER_TIMEOUT_EN
    exp_q.push_back({7'h41, 70'd0});
    waited = 0;
    while (!StringValid && waited < 40) begin
      tick();
      waited++;
    end
    chk("timeout_cycles", waited, 20);
    chk("timeout_valid", StringValid, 1'b1);
    StringAck = 1'b1; tick(); StringAck = 1'b0;
`else
    waited = 0;
    repeat (1000) tick();
    chk("no_timeout_valid", StringValid, 1'b0);
    chk("no_timeout_count", CharCount, 4'd1);
`endif

    tick(); tick();
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
